// File: rtl/multiword_adder_pkg.sv
// Shared types for the multi-word adder: FSM state encodings
// and the chunk-counter width helper.
package multiword_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold 0..WORDS without wrapping.
    function automatic int cnt_width(input int words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/multiword_adder_if.sv
// Operand/result handshake bundle for multiword_adder.
// master = operand source + result sink, slave = the adder.
interface multiword_adder_if #(
    parameter int NBITS = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] in_a;
    logic [NBITS-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/multiword_adder_prefix.sv
// PrefixAdder: WIDTH-bit Kogge-Stone adder with carry in/out.
// Ports: a, b, cin, sub (inverts b and forces carry-in), sum, cout.
module PrefixAdder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int LV = $clog2(WIDTH);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             ci;

    always_comb begin
        bx = b ^ {WIDTH{sub}};
        ci = cin | sub;
        p0 = a ^ bx;
        g  = a & bx;
        p  = p0;
        // Fold carry-in into bit 0 so group generates are true carries.
        g[0] = g[0] | (p0[0] & ci);
        for (int k = 0; k < LV; k++) begin
            // High-to-low so each level reads the previous level's values.
            for (int i = WIDTH - 1; i >= (1 << k); i--) begin
                g[i] = g[i] | (p[i] & g[i - (1 << k)]);
                p[i] = p[i] & p[i - (1 << k)];
            end
        end
        sum  = p0 ^ {g[WIDTH-2:0], ci};
        cout = g[WIDTH-1];
    end

endmodule

// File: rtl/multiword_adder.sv
// Sequential NBITS add/sub, one WIDTH-bit chunk per cycle, LSB first.
// Ports: clk, rst (sync, active-high), bus (slave handshake bundle).
module multiword_adder
    import multiword_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    multiword_adder_if.slave   bus
);
    localparam int NBITS = WIDTH * WORDS;
    localparam int CW    = cnt_width(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_t           state;
    logic [NBITS-1:0] a_q;
    logic [NBITS-1:0] b_q;
    logic [NBITS-1:0] s_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             rdy;
    logic             vld;
    logic [NBITS-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [WIDTH-1:0] csum;
    logic             ccout;
    logic [NBITS-1:0] s_nxt;
    logic             cmsb;

    PrefixAdder #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (a_q[WIDTH-1:0]),
        .b    (b_q[WIDTH-1:0]),
        .cin  (carry),
        .sub  (1'b0),
        .sum  (csum),
        .cout (ccout)
    );

    // Sum shift register fills from the top.
    generate
        if (WORDS == 1) begin : g_one
            assign s_nxt = csum;
        end else begin : g_many
            assign s_nxt = {csum, s_q[NBITS-1:WIDTH]};
        end
    endgenerate

    // Carry into the MSB, valid while the top chunk is in the adder.
    assign cmsb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ csum[WIDTH-1];

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            rdy    <= 1'b1;
            vld    <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_valid && rdy) begin
                        a_q   <= bus.in_a;
                        b_q   <= bus.in_b ^ {NBITS{bus.in_sub}};
                        carry <= bus.in_sub;
                        cnt   <= '0;
                        rdy   <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry <= ccout;
                    a_q   <= a_q >> WIDTH;
                    b_q   <= b_q >> WIDTH;
                    s_q   <= s_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q  <= s_nxt;
                        cout_q <= ccout;
                        ovf_q  <= cmsb ^ ccout;
                        vld    <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (vld && bus.out_ready) begin
                        vld   <= 1'b0;
                        rdy   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
